// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store front end for a word/byte data memory.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_i, we_i         : request valid (held while stall_o), 1=store
//   funct3_i            : RV32I width/sign code
//   addr_i, wd_i        : byte address, store data
//   rd_o                : extended load result, valid with done_o
//   done_o, stall_o     : access completes / more beats pending
//   err_o               : illegal funct3 this cycle
//   mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o, mem_rd_i : data memory side
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  done_o,
    output logic                  stall_o,
    output logic                  err_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_op_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);
    localparam int DW = DATA_WIDTH;
    localparam int BW = BYTE_WIDTH;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t          r_state, w_next;
    logic [1:0]      r_cnt;
    logic [DW-BW-1:0] r_acc;
    logic [DW-1:0]   r_base, r_wd;
    logic [2:0]      r_f3;
    logic            r_we;
    logic            w_busy, w_we, w_legal, w_split, w_last, w_go, w_start, w_act, w_ld, w_sign;
    logic [2:0]      w_f3;
    logic [1:0]      w_cnt;
    logic [DW-1:0]   w_base, w_wd;
    logic [DW-BW-1:0] w_byte;
    // While busy the latched request drives everything, so live inputs cannot disturb beats
    assign w_busy  = r_state == BUSY;
    assign w_f3    = w_busy ? r_f3 : funct3_i;
    assign w_we    = w_busy ? r_we : we_i;
    assign w_base  = w_busy ? r_base : addr_i;
    assign w_wd    = w_busy ? r_wd : wd_i;
    assign w_cnt   = w_busy ? r_cnt : 2'd0;
    assign w_legal = (~w_f3[2] & (w_f3[1:0] != 2'b11)) | (~w_we & w_f3[2] & ~w_f3[1]);
    assign w_split = (w_f3[1:0] == 2'b01) | ((w_f3[1:0] == 2'b10) & (w_base[1:0] != 2'b00));
    assign w_last  = w_busy & (r_cnt == ((r_f3[1:0] == 2'b01) ? 2'd1 : 2'd3));
    assign w_go    = rst_n & ~w_busy & req_i;
    assign w_start = w_go & w_legal & w_split;
    // Gating by rst_n stops any beat the moment reset asserts, even mid-split
    assign w_act   = rst_n & (w_busy | (req_i & w_legal));
    assign mem_we_o      = w_act & w_we;
    assign mem_byte_op_o = w_act & (w_split | (w_f3[1:0] == 2'b00));
    assign mem_addr_o    = w_act ? w_base + DW'(w_cnt) : '0;
    assign mem_wd_o      = mem_we_o ? (mem_byte_op_o ? (w_wd >> (BW * w_cnt)) & DW'({BW{1'b1}}) : w_wd) : '0;
    assign err_o   = w_go & ~w_legal;
    assign done_o  = (w_go & ~(w_legal & w_split)) | (rst_n & w_last);
    assign stall_o = w_start | (rst_n & w_busy & ~w_last);
    assign w_ld    = done_o & ~w_we & w_legal;
    assign w_sign  = ~w_f3[2] & mem_rd_i[BW-1];
    assign w_byte  = {{(DW-2*BW){1'b0}}, mem_rd_i[BW-1:0]};
    assign rd_o = ~w_ld ? '0 :
                  (w_f3[1:0] == 2'b00) ? {{(DW-BW){w_sign}}, mem_rd_i[BW-1:0]} :
                  (w_f3[1:0] == 2'b01) ? {{(DW-2*BW){w_sign}}, mem_rd_i[BW-1:0], r_acc[BW-1:0]} :
                  w_split ? {mem_rd_i[BW-1:0], r_acc} : mem_rd_i;
    always_comb begin
        w_next = r_state;
        if (w_start)
            w_next = BUSY;
        else if (w_last)
            w_next = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    // The final beat is consumed straight from mem_rd_i, so acc only holds the earlier bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_base <= '0;
            r_wd   <= '0;
            r_f3   <= '0;
            r_we   <= 1'b0;
        end else if (w_start) begin
            r_cnt  <= 2'd1;
            r_acc  <= w_byte;
            r_base <= addr_i;
            r_wd   <= wd_i;
            r_f3   <= funct3_i;
            r_we   <= we_i;
        end else if (w_busy) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 2'd1;
                r_acc <= r_acc | (w_byte << (BW * r_cnt));
            end
        end
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and data_memory.
- Translates RV32I load/store requests (LB, LH, LW, LBU, LHU, SB, SH, SW) into the memory's two access modes: aligned word, or single byte with byte_op.
- Halfword and misaligned-word accesses are split into sequential byte beats. The pipeline is stalled while beats are in flight.
- Loads are sign- or zero-extended here.

Parameters:
- DATA_WIDTH, 32, data/address width.
- BYTE_WIDTH, 8, byte width; beat data size.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  1  memory request valid; held stable by upstream while stall_o=1.
- we_i  input  1  1=store, 0=load.
- funct3_i  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- addr_i  input  DATA_WIDTH  byte address.
- wd_i  input  DATA_WIDTH  store data.
- rd_o  output  DATA_WIDTH  extended load result; valid when done_o=1.
- done_o  output  1  access completes this cycle.
- stall_o  output  1  hold pipeline; more beats pending.
- err_o  output  1  illegal funct3 this cycle.
- mem_we_o  output  1  to data_memory we_i.
- mem_byte_op_o  output  1  to data_memory byte_op_i.
- mem_addr_o  output  DATA_WIDTH  to data_memory addr_i.
- mem_wd_o  output  DATA_WIDTH  to data_memory wd_i.
- mem_rd_i  input  DATA_WIDTH  from data_memory rd_o. Combinational read; a byte read returns the zero-extended byte in [7:0].

Behaviour:
- Access classes:
  - Single-cycle:
    - W with addr[1:0]=00: byte_op=0, addr passed through.
    - B/BU: byte_op=1.
  - Split: H/HU (any address) = 2 beats; W with addr[1:0]≠00 = 4 beats.
  - Beat k: byte_op=1, mem_addr_o=base+k (mod 2^32). Store beats send wd[8k+7:8k] in mem_wd_o[7:0].
- FSM states: IDLE, BUSY. Beat counter cnt[1:0]. Latched base address, wd, funct3, we.
- IDLE, req_i=0: all mem_* and status outputs 0, rd_o=0.
- IDLE, req_i=1, single-cycle class:
  - Drive the memory combinationally in the same cycle.
  - done_o=1, stall_o=0; remain in IDLE.
- IDLE, req_i=1, split class:
  - Issue beat 0 from the live inputs.
  - Latch the request; capture the load byte into acc[7:0].
  - stall_o=1, done_o=0. Next state BUSY, cnt=1.
- BUSY:
  - Issue beat cnt from the latched request; live inputs are ignored.
  - Load bytes go into acc[8cnt+7:8cnt].
  - If cnt=N-1: done_o=1, stall_o=0, next state IDLE.
  - Otherwise stall_o=1, cnt+1.
- Latency: single-cycle class 1 cycle; H/HU 2 cycles; misaligned W 4 cycles.
- A new request may be issued in the cycle after done_o (back-to-back).
- Load extension:
  - LB: sign-extend bit 7. LBU: zero-extend.
  - LH: sign-extend bit 15 of {mem_rd_i[7:0], acc[7:0]}. LHU: zero-extend.
  - Misaligned LW: {mem_rd_i[7:0], acc[23:0]}.
  - Aligned LW: mem_rd_i unchanged.
- rd_o on stores is 0.
- Illegal funct3 (011, 110, 111; or 100/101 with we_i=1):
  - Single cycle: err_o=1, done_o=1, mem_we_o=0, rd_o=0. No state change.
- data_memory writes on the falling edge. mem_we_o, mem_addr_o and mem_wd_o must be stable from the rising edge through the falling edge. They are therefore derived only from registered state and stable inputs.
- Reset:
  - rst_n low forces IDLE, cnt=0, acc=0, latches=0 asynchronously.
  - mem_we_o, stall_o, done_o and err_o are gated to 0 while rst_n=0, including mid-split; no further beats are issued.
  - After release with req_i still high, the access restarts at beat 0.

Test Plan:
- LW @0x10004, mem bytes 11,22,33,44 → same cycle: mem_byte_op_o=0, rd_o=0x44332211, done_o=1, stall_o=0.
- LB then LBU @0x10001, byte 0x80 → rd_o=0xFFFFFF80, then 0x00000080; each takes 1 cycle.
- SH @0x10003, wd=0xABCD1234 → cycle0: byte 0x34 written to 0x10003, stall_o=1; cycle1: 0x12 written to 0x10004, done_o=1. Bytes 0x10002 and 0x10005 unchanged.
- LW @0x10001, bytes 0x10001..4 = AA,BB,CC,DD → stall_o sequence 1,1,1,0; rd_o=0xDDCCBBAA on cycle 4. Input addr changed mid-sequence has no effect.
- SW @0x10002 with rst_n pulsed low during beat 2 → mem_we_o=0 immediately, FSM IDLE. After release with req_i held, all 4 beats re-issue from 0x10002 and final memory holds the full word.
- funct3=011 load and funct3=100 store → err_o=1, done_o=1, mem_we_o=0, rd_o=0, memory unchanged.
